// File: rtl/hazard_pkg.sv
// Shared defaults, forward-select encoding and entry record for the D-stage hazard scoreboard.
package hazard_pkg;

  localparam int STAGES_DEF   = 3;
  localparam int RA_W_DEF     = 5;
  localparam int T_W_DEF      = 3;
  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  typedef struct packed {
    logic [RA_W_DEF-1:0] wa;
    logic [T_W_DEF-1:0]  tnew;
  } sb_entry_t;

  // Map a scoreboard slot index to the forward-select code of that pipeline stage.
  function automatic logic [1:0] fwd_of_stage(input int k);
    case (k)
      0:       return FWD_E;
      1:       return FWD_M;
      default: return FWD_W;
    endcase
  endfunction

endpackage

// File: rtl/hazard_md_timer.sv
// HI/LO unit busy timer: loads the mult or div latency on an accepted start, then counts down.
module hazard_md_timer
  import hazard_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic div,
  output logic busy
);

  localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (start) begin
      count <= div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// D-stage hazard scoreboard: ages in-flight producers, derives stall and forward selects.
// Optional stall statistics counters are enabled by defining HAZARD_STATS_EN.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int STAGES   = STAGES_DEF,
  parameter int RA_W     = RA_W_DEF,
  parameter int T_W      = T_W_DEF,
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [RA_W-1:0] d_rs,
  input  logic [RA_W-1:0] d_rt,
  input  logic [T_W-1:0]  d_tuse_rs,
  input  logic [T_W-1:0]  d_tuse_rt,
  input  logic [RA_W-1:0] d_wa,
  input  logic [T_W-1:0]  d_tnew,
  input  logic            d_md_use,
  input  logic            d_md_start,
  input  logic            d_md_div,
`ifdef HAZARD_STATS_EN
  output logic [31:0]     stall_cnt,
  output logic [31:0]     md_stall_cnt,
`endif
  output logic            stall,
  output logic [1:0]      fwd_rs_sel,
  output logic [1:0]      fwd_rt_sel,
  output logic            md_busy
);

  logic [RA_W-1:0] wa   [STAGES];
  logic [T_W-1:0]  tnew [STAGES];

  logic rs_stall;
  logic rt_stall;
  logic md_stall;

  // Slot 0 takes the D instruction (or a bubble when stalled); older slots age toward zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < STAGES; k++) begin
        wa[k]   <= '0;
        tnew[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES - 1; k++) begin
        wa[k+1]   <= wa[k];
        tnew[k+1] <= (tnew[k] == '0) ? '0 : tnew[k] - T_W'(1);
      end
      wa[0]   <= stall ? '0 : d_wa;
      tnew[0] <= stall ? '0 : d_tnew;
    end
  end

  // Scan oldest to youngest so the youngest matching producer has the final say.
  always_comb begin
    rs_stall   = 1'b0;
    rt_stall   = 1'b0;
    fwd_rs_sel = FWD_RF;
    fwd_rt_sel = FWD_RF;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (d_rs != '0 && wa[k] == d_rs) begin
        rs_stall   = (tnew[k] > d_tuse_rs);
        fwd_rs_sel = (tnew[k] == '0) ? fwd_of_stage(k) : FWD_RF;
      end
      if (d_rt != '0 && wa[k] == d_rt) begin
        rt_stall   = (tnew[k] > d_tuse_rt);
        fwd_rt_sel = (tnew[k] == '0) ? fwd_of_stage(k) : FWD_RF;
      end
    end
  end

  assign md_stall = d_md_use & md_busy;
  assign stall    = rs_stall | rt_stall | md_stall;

  hazard_md_timer #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md_timer (
    .clk   (clk),
    .reset (reset),
    .start (d_md_start & ~stall),
    .div   (d_md_div),
    .busy  (md_busy)
  );

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt    <= '0;
      md_stall_cnt <= '0;
    end else begin
      if (stall && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (md_stall && md_stall_cnt != '1) begin
        md_stall_cnt <= md_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard with hand-derived expectations.
module tb_hazard_scoreboard;

  logic       clk;
  logic       reset;
  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic [2:0] d_tuse_rs;
  logic [2:0] d_tuse_rt;
  logic [4:0] d_wa;
  logic [2:0] d_tnew;
  logic       d_md_use;
  logic       d_md_start;
  logic       d_md_div;
  logic       stall;
  logic [1:0] fwd_rs_sel;
  logic [1:0] fwd_rt_sel;
  logic       md_busy;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] md_stall_cnt;
`endif

  int test_count = 0;
  int fail_count = 0;

  hazard_scoreboard dut (
    .clk          (clk),
    .reset        (reset),
    .d_rs         (d_rs),
    .d_rt         (d_rt),
    .d_tuse_rs    (d_tuse_rs),
    .d_tuse_rt    (d_tuse_rt),
    .d_wa         (d_wa),
    .d_tnew       (d_tnew),
    .d_md_use     (d_md_use),
    .d_md_start   (d_md_start),
    .d_md_div     (d_md_div),
`ifdef HAZARD_STATS_EN
    .stall_cnt    (stall_cnt),
    .md_stall_cnt (md_stall_cnt),
`endif
    .stall        (stall),
    .fwd_rs_sel   (fwd_rs_sel),
    .fwd_rt_sel   (fwd_rt_sel),
    .md_busy      (md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] rs, input logic [2:0] tuse_rs,
                               input logic [4:0] rt, input logic [2:0] tuse_rt,
                               input logic [4:0] wa, input logic [2:0] tnew,
                               input logic md_use, input logic md_start, input logic md_div);
    d_rs       = rs;
    d_tuse_rs  = tuse_rs;
    d_rt       = rt;
    d_tuse_rt  = tuse_rt;
    d_wa       = wa;
    d_tnew     = tnew;
    d_md_use   = md_use;
    d_md_start = md_start;
    d_md_div   = md_div;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Counts consecutive stalled cycles with inputs held, giving up after 20.
  task automatic countStall(output int n);
    n = 0;
    while (stall && n < 20) begin
      n++;
      nextCycle();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    reset = 1'b0;
    applyStimulus(5'd3, 3'd0, 5'd4, 3'd0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    repeat (2) nextCycle();
    checkOutput("reset_stall", stall, 1'b0);
    checkOutput("reset_fwd_rs", fwd_rs_sel, 2'd0);
    checkOutput("reset_fwd_rt", fwd_rt_sel, 2'd0);
    checkOutput("reset_md_busy", md_busy, 1'b0);
    reset = 1'b1;

    // lw $3 (tnew 2) followed by a reader of $3 with tuse 1
    applyStimulus(5'd0, 3'd0, 5'd0, 3'd0, 5'd3, 3'd2, 1'b0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(5'd3, 3'd1, 5'd0, 3'd0, 5'd8, 3'd1, 1'b0, 1'b0, 1'b0);
    checkOutput("lw_use_stall", stall, 1'b1);
    nextCycle();
    checkOutput("lw_use_release", stall, 1'b0);
    checkOutput("lw_use_fwd_rs_m_tnew1", fwd_rs_sel, 2'd0);
    nextCycle();
    applyStimulus(5'd3, 3'd0, 5'd8, 3'd1, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("lw_in_w_stall", stall, 1'b0);
    checkOutput("lw_in_w_fwd_rs", fwd_rs_sel, 2'd3);
    checkOutput("addu_in_m_fwd_rt", fwd_rt_sel, 2'd0);
    nextCycle();

    // addu $5 (tnew 1) then beq on $5 (tuse 0)
    applyStimulus(5'd0, 3'd0, 5'd0, 3'd0, 5'd5, 3'd1, 1'b0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(5'd5, 3'd0, 5'd0, 3'd0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("beq_stall", stall, 1'b1);
    nextCycle();
    checkOutput("beq_release", stall, 1'b0);
    checkOutput("beq_fwd_rs", fwd_rs_sel, 2'd2);
    nextCycle();

    // ori $4 in E with tnew 0, reader of rt with tuse 2
    applyStimulus(5'd0, 3'd0, 5'd0, 3'd0, 5'd4, 3'd0, 1'b0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(5'd0, 3'd0, 5'd4, 3'd2, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("ori_stall", stall, 1'b0);
    checkOutput("ori_fwd_rt", fwd_rt_sel, 2'd1);
    checkOutput("ori_fwd_rs_zero_reg", fwd_rs_sel, 2'd0);
    nextCycle();

    // Two writers of $6: older one still has tnew 1 in M, younger has tnew 0 in E
    applyStimulus(5'd0, 3'd0, 5'd0, 3'd0, 5'd6, 3'd2, 1'b0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(5'd0, 3'd0, 5'd0, 3'd0, 5'd6, 3'd0, 1'b0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(5'd6, 3'd0, 5'd6, 3'd0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("shadow_stall", stall, 1'b0);
    checkOutput("shadow_fwd_rs", fwd_rs_sel, 2'd1);
    checkOutput("shadow_fwd_rt", fwd_rt_sel, 2'd1);
    nextCycle();

    // mult, then a second mult held behind it; the stalled start must not reload
    applyStimulus(5'd0, 3'd0, 5'd0, 3'd0, 5'd0, 3'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("mult_issue_stall", stall, 1'b0);
    nextCycle();
    countStall(n);
    checkOutput("mult_stall_cycles", n, 5);
    checkOutput("mult_md_busy_released", md_busy, 1'b0);
    nextCycle();
    applyStimulus(5'd0, 3'd0, 5'd0, 3'd0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("mult2_busy", md_busy, 1'b1);
    repeat (4) nextCycle();
    checkOutput("mult2_busy_last", md_busy, 1'b1);
    nextCycle();
    checkOutput("mult2_idle", md_busy, 1'b0);

    // div then mfhi
    applyStimulus(5'd0, 3'd0, 5'd0, 3'd0, 5'd0, 3'd0, 1'b1, 1'b1, 1'b1);
    checkOutput("div_issue_stall", stall, 1'b0);
    nextCycle();
    applyStimulus(5'd0, 3'd0, 5'd0, 3'd0, 5'd9, 3'd1, 1'b1, 1'b0, 1'b0);
    checkOutput("div_md_busy", md_busy, 1'b1);
    countStall(n);
    checkOutput("div_stall_cycles", n, 10);
    checkOutput("mfhi_release_stall", stall, 1'b0);
    checkOutput("mfhi_release_busy", md_busy, 1'b0);
    nextCycle();

    // Reset mid-divide with valid entries in flight (counter reaches 7)
    applyStimulus(5'd0, 3'd0, 5'd0, 3'd0, 5'd0, 3'd0, 1'b1, 1'b1, 1'b1);
    nextCycle();
    applyStimulus(5'd0, 3'd0, 5'd0, 3'd0, 5'd10, 3'd2, 1'b0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(5'd0, 3'd0, 5'd0, 3'd0, 5'd11, 3'd2, 1'b0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(5'd0, 3'd0, 5'd0, 3'd0, 5'd12, 3'd2, 1'b0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(5'd10, 3'd3, 5'd11, 3'd3, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_reset_stall", stall, 1'b0);
    checkOutput("pre_reset_fwd_rs", fwd_rs_sel, 2'd3);
    checkOutput("pre_reset_fwd_rt", fwd_rt_sel, 2'd0);
    applyStimulus(5'd10, 3'd3, 5'd11, 3'd3, 5'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("pre_reset_md_stall", stall, 1'b1);
    reset = 1'b0;
    nextCycle();
    reset = 1'b1;
    applyStimulus(5'd10, 3'd0, 5'd11, 3'd0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("post_reset_stall", stall, 1'b0);
    checkOutput("post_reset_md_busy", md_busy, 1'b0);
    checkOutput("post_reset_fwd_rs", fwd_rs_sel, 2'd0);
    checkOutput("post_reset_fwd_rt", fwd_rt_sel, 2'd0);
    nextCycle();
    checkOutput("post_reset_md_busy_stays", md_busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
